// File: rtl/priority_arbiter_n.sv
// priority_arbiter_n
//   Bus-drive arbiter for N_CH sources sharing one tri-state bus. It produces
//   registered one-hot buffer enables (ie). The winner is chosen by fixed
//   priority with a selectable preferred channel, or by round-robin. An owner
//   keeps the bus while it requests. It is preempted after MAX_HOLD cycles when
//   another channel is waiting. Between owners, ie stays all-low for an
//   all-off turnaround gap.
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   req           per-channel level request, held while the bus is needed
//   use_priority  1 = fixed priority (prio_ch preferred), 0 = round-robin
//   prio_ch       preferred channel in fixed-priority mode (>= N_CH: none)
//   ie            registered one-hot buffer enables, zero when the bus is idle
//   grant_valid   high while some ie bit is high
//   grant_id      current owner; keeps the last owner while not valid
module priority_arbiter_n #(
  parameter int N_CH       = 4,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1,
  localparam int CH_W      = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] req,
  input  logic            use_priority,
  input  logic [CH_W-1:0] prio_ch,
  output logic [N_CH-1:0] ie,
  output logic            grant_valid,
  output logic [CH_W-1:0] grant_id
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [2:0]        REL_LAST  = 3'(TURNAROUND - 1);
  localparam logic [N_CH-1:0]   ONE_HOT0  = N_CH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t            state_r,      state_n_s;
  logic [N_CH-1:0]   ie_r,         ie_n_s;
  logic              gv_r,         gv_n_s;
  logic [CH_W-1:0]   gid_r,        gid_n_s;
  logic [CH_W-1:0]   last_grant_r, last_grant_n_s;
  logic [HOLD_W-1:0] hold_cnt_r,   hold_cnt_n_s;
  logic [2:0]        rel_cnt_r,    rel_cnt_n_s;

  logic [CH_W-1:0]   fx_win_s;
  logic [CH_W-1:0]   rr_win_s;
  logic [CH_W-1:0]   win_s;
  int                rr_best_s;
  logic              owner_req_s;
  logic              others_req_s;

  // Round-robin distance of channel idx from the slot right after the last owner.
  function automatic int rr_dist(input int idx, input logic [CH_W-1:0] last);
    return (idx + N_CH - 1 - int'(last)) % N_CH;
  endfunction

  // Fixed-priority winner: the preferred channel if it requests, else the lowest requester.
  always_comb begin
    fx_win_s = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        fx_win_s = CH_W'(i);
      end else begin
        fx_win_s = fx_win_s;
      end
    end
    // An out-of-range prio_ch matches no channel, so the lowest requester stands.
    for (int i = 0; i < N_CH; i++) begin
      if (req[i] && (prio_ch == CH_W'(i))) begin
        fx_win_s = CH_W'(i);
      end else begin
        fx_win_s = fx_win_s;
      end
    end
  end

  // Round-robin winner: the requester closest after last_grant, wrapping around.
  always_comb begin
    rr_win_s  = '0;
    rr_best_s = N_CH;
    for (int i = 0; i < N_CH; i++) begin
      if (req[i] && (rr_dist(i, last_grant_r) < rr_best_s)) begin
        rr_best_s = rr_dist(i, last_grant_r);
        rr_win_s  = CH_W'(i);
      end else begin
        rr_best_s = rr_best_s;
        rr_win_s  = rr_win_s;
      end
    end
  end

  // Mode select. The result is only consumed in IDLE, so changes to the mode
  // inputs during GRANT cannot move the owner.
  always_comb begin
    win_s = use_priority ? fx_win_s : rr_win_s;
  end

  // ie_r is one-hot on the owner, so it doubles as the owner mask.
  always_comb begin
    owner_req_s  = |(req & ie_r);
    others_req_s = |(req & ~ie_r);
  end

  // FSM next state and next values of every registered output and counter.
  always_comb begin
    state_n_s      = state_r;
    ie_n_s         = ie_r;
    gv_n_s         = gv_r;
    gid_n_s        = gid_r;
    last_grant_n_s = last_grant_r;
    hold_cnt_n_s   = hold_cnt_r;
    rel_cnt_n_s    = rel_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_n_s    = ST_GRANT;
          ie_n_s       = ONE_HOT0 << win_s;
          gv_n_s       = 1'b1;
          gid_n_s      = win_s;
          hold_cnt_n_s = '0;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (hold_cnt_r < HOLD_MAX) begin
          hold_cnt_n_s = hold_cnt_r + HOLD_W'(1);
        end else begin
          hold_cnt_n_s = hold_cnt_r;
        end
        // Preemption fires only on the exact cycle the hold count reaches
        // MAX_HOLD-1. A lone owner that has already saturated keeps the bus.
        if (!owner_req_s ||
            ((MAX_HOLD > 0) && (hold_cnt_r == HOLD_LAST) && others_req_s)) begin
          state_n_s      = ST_RELEASE;
          ie_n_s         = '0;
          gv_n_s         = 1'b0;
          last_grant_n_s = gid_r;
          rel_cnt_n_s    = '0;
        end else begin
          state_n_s = ST_GRANT;
        end
      end
      ST_RELEASE: begin
        if (rel_cnt_r == REL_LAST) begin
          state_n_s = ST_IDLE;
        end else begin
          rel_cnt_n_s = rel_cnt_r + 3'd1;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        ie_n_s    = '0;
        gv_n_s    = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset drops the bus enables immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      ie_r         <= '0;
      gv_r         <= 1'b0;
      gid_r        <= '0;
      last_grant_r <= CH_W'(N_CH - 1);
      hold_cnt_r   <= '0;
      rel_cnt_r    <= 3'd0;
    end else begin
      state_r      <= state_n_s;
      ie_r         <= ie_n_s;
      gv_r         <= gv_n_s;
      gid_r        <= gid_n_s;
      last_grant_r <= last_grant_n_s;
      hold_cnt_r   <= hold_cnt_n_s;
      rel_cnt_r    <= rel_cnt_n_s;
    end
  end

  assign ie          = ie_r;
  assign grant_valid = gv_r;
  assign grant_id    = gid_r;

endmodule

// File: tb/tb_priority_arbiter_n.sv
module tb_priority_arbiter_n;

  localparam int NC   = 4;
  localparam int MH   = 8;
  localparam int TA   = 1;
  localparam int NVEC = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       use_priority;
  logic [3:0] req4;
  logic [1:0] prio4;
  logic [3:0] ie4;
  logic       gv4;
  logic [1:0] gid4;
  logic [7:0] req8;
  logic [2:0] prio8;
  logic [7:0] ie8;
  logic       gv8;
  logic [2:0] gid8;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit         wide;
    bit         up;
    logic [2:0] prio;
    logic [7:0] req;
    logic [7:0] exp_ie;
    logic [2:0] exp_gid;
  } vec_t;

  vec_t tbl [NVEC];

  // Higher-level reference model state.
  int m_owner;
  int m_owned;
  int m_gap;
  int m_last;
  int m_gid;

  priority_arbiter_n #(.N_CH(NC), .MAX_HOLD(MH), .TURNAROUND(TA)) dut4 (
    .clk(clk), .reset_n(reset_n), .req(req4), .use_priority(use_priority),
    .prio_ch(prio4), .ie(ie4), .grant_valid(gv4), .grant_id(gid4));

  priority_arbiter_n #(.N_CH(8), .MAX_HOLD(MH), .TURNAROUND(TA)) dut8 (
    .clk(clk), .reset_n(reset_n), .req(req8), .use_priority(use_priority),
    .prio_ch(prio8), .ie(ie8), .grant_valid(gv8), .grant_id(gid8));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] r, input logic up, input int p);
    if (r == 4'b0000) return -1;
    if (up) begin
      if (p < NC && r[p]) return p;
      for (int i = 0; i < NC; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= NC; k++) if (r[(m_last + k) % NC]) return (m_last + k) % NC;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_owned = 0;
    m_gap   = 0;
    m_last  = NC - 1;
    m_gid   = 0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step();
    int  w;
    bit  others;
    if (m_owner >= 0) begin
      others = (req4 & ~(4'b0001 << m_owner)) != 4'b0000;
      if (!req4[m_owner] || (MH > 0 && m_owned == MH && others)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = TA;
      end else begin
        m_owned++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      w = pick(req4, use_priority, int'(prio4));
      if (w >= 0) begin
        m_owner = w;
        m_owned = 1;
        m_gid   = w;
      end
    end
  endtask

  initial begin
    logic [3:0] exp_ie4;
    int         ch;
    int         j;

    tbl[0] = '{1'b0, 1'b1, 3'd2, 8'h0D, 8'h04, 3'd2};
    tbl[1] = '{1'b0, 1'b1, 3'd2, 8'h0B, 8'h01, 3'd0};
    tbl[2] = '{1'b0, 1'b1, 3'd0, 8'h08, 8'h08, 3'd3};
    tbl[3] = '{1'b0, 1'b1, 3'd3, 8'h0E, 8'h08, 3'd3};
    tbl[4] = '{1'b0, 1'b0, 3'd0, 8'h0F, 8'h01, 3'd0};
    tbl[5] = '{1'b0, 1'b0, 3'd0, 8'h0C, 8'h04, 3'd2};
    tbl[6] = '{1'b0, 1'b1, 3'd1, 8'h00, 8'h00, 3'd0};
    tbl[7] = '{1'b1, 1'b1, 3'd7, 8'h30, 8'h10, 3'd4};
    tbl[8] = '{1'b1, 1'b1, 3'd5, 8'h30, 8'h20, 3'd5};
    tbl[9] = '{1'b1, 1'b0, 3'd0, 8'h80, 8'h80, 3'd7};

    reset_n      = 1'b0;
    use_priority = 1'b1;
    req4 = 4'h0; prio4 = 2'd0; req8 = 8'h00; prio8 = 3'd0;
    #12;
    check("reset_ie4", 32'(ie4), 32'h0);
    check("reset_gv4", 32'(gv4), 32'h0);
    check("reset_gid4", 32'(gid4), 32'h0);
    check("reset_ie8", 32'(ie8), 32'h0);
    reset_n = 1'b1;

    // Table-driven single arbitrations from a fresh reset.
    for (int v = 0; v < NVEC; v++) begin
      req4 = 4'h0; req8 = 8'h00;
      do_reset();
      use_priority = tbl[v].up;
      if (tbl[v].wide) begin
        prio8 = tbl[v].prio;
        req8  = tbl[v].req;
      end else begin
        prio4 = tbl[v].prio[1:0];
        req4  = tbl[v].req[3:0];
      end
      tick();
      if (tbl[v].wide) begin
        check($sformatf("vec%0d_ie", v), 32'(ie8), 32'(tbl[v].exp_ie));
        check($sformatf("vec%0d_gid", v), 32'(gid8), 32'(tbl[v].exp_gid));
        check($sformatf("vec%0d_gv", v), 32'(gv8), 32'(tbl[v].exp_ie != 8'h00));
      end else begin
        check($sformatf("vec%0d_ie", v), 32'(ie4), 32'(tbl[v].exp_ie));
        check($sformatf("vec%0d_gid", v), 32'(gid4), 32'(tbl[v].exp_gid));
        check($sformatf("vec%0d_gv", v), 32'(gv4), 32'(tbl[v].exp_ie != 8'h00));
      end
    end
    req8 = 8'h00;

    // Asynchronous reset in the middle of a grant.
    req4 = 4'h0;
    do_reset();
    use_priority = 1'b1; prio4 = 2'd2; req4 = 4'b0100;
    tick();
    tick();
    check("midgrant_ie_before", 32'(ie4), 32'h4);
    #2 reset_n = 1'b0;
    #1;
    check("midgrant_rst_ie", 32'(ie4), 32'h0);
    check("midgrant_rst_gv", 32'(gv4), 32'h0);
    check("midgrant_rst_gid", 32'(gid4), 32'h0);
    @(negedge clk);
    req4 = 4'h0;
    reset_n = 1'b1;

    // Round-robin rotation with all channels requesting: 8 on, 2 off, next channel.
    do_reset();
    use_priority = 1'b0; req4 = 4'b1111;
    for (int t = 1; t <= 40; t++) begin
      tick();
      ch = ((t - 1) / 10) % NC;
      exp_ie4 = (((t - 1) % 10) < 8) ? (4'b0001 << ch) : 4'b0000;
      check($sformatf("rr_ie_t%0d", t), 32'(ie4), 32'(exp_ie4));
      check($sformatf("rr_gid_t%0d", t), 32'(gid4), 32'(ch));
    end

    // Lone requester is never preempted.
    req4 = 4'h0;
    do_reset();
    req4 = 4'b0010;
    for (int t = 1; t <= 40; t++) begin
      tick();
      check($sformatf("lone_ie_t%0d", t), 32'(ie4), 32'h2);
    end

    // Owner drops its request; the waiting channel gets the bus after the gap.
    req4 = 4'h0;
    do_reset();
    use_priority = 1'b1; prio4 = 2'd1; req4 = 4'b1010;
    tick();
    check("rel_own_ie", 32'(ie4), 32'h2);
    tick();
    tick();
    @(negedge clk);
    req4 = 4'b1000;
    tick();
    check("rel_k1_ie", 32'(ie4), 32'h0);
    check("rel_k1_gid", 32'(gid4), 32'h1);
    tick();
    check("rel_k2_ie", 32'(ie4), 32'h0);
    tick();
    check("rel_k3_ie", 32'(ie4), 32'h8);
    check("rel_k3_gid", 32'(gid4), 32'h3);

    // Randomized traffic against the reference model.
    req4 = 4'h0;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        j = $urandom_range(0, 3);
        req4[j] = ~req4[j];
      end
      if ($urandom_range(0, 39) == 0) req4 = 4'($urandom);
      if ($urandom_range(0, 31) == 0) use_priority = 1'($urandom);
      if ($urandom_range(0, 31) == 0) prio4 = 2'($urandom);
      @(posedge clk);
      model_step();
      #1;
      exp_ie4 = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check($sformatf("rand_ie_c%0d", c), 32'(ie4), 32'(exp_ie4));
      check($sformatf("rand_gv_c%0d", c), 32'(gv4), 32'(m_owner >= 0));
      check($sformatf("rand_gid_c%0d", c), 32'(gid4), 32'(m_gid));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
